uart_rx_engine: RTL and testbench

Asynchronous serial (UART) receive engine for the CECS460 UART peripheral.
- Oversamples the RX line on the system clock at a rate selected by BAUD and deserialises 7- or 8-bit frames, LSB first, with optional odd/even parity.
- Presents the received byte, a one-cycle frame-done strobe and per-frame error flags to the host-side status/read logic.
- Sits between the board RX pin and the UART register interface.

---
 rtl/uart_pkg.sv | 55 +++++
 rtl/uart_bit_timer.sv | 45 ++++
 rtl/uart_rx_engine.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: shared definitions for the UART receive engine.
//   - rx_state_t      : receive FSM state encoding
//   - BT_W / SHIFT_W  : bit-timer and shift-register widths
//   - baud_bt()       : BAUD code -> bit time in system clocks
//   - frame_mask()    : mask of the first n sampled frame bits
//   - expected_parity(): parity bit a correct transmitter would send
package uart_pkg;

  localparam int BT_W    = 20;  // wide enough for 333333 clocks
  localparam int SHIFT_W = 9;   // up to 8 data bits plus parity

  localparam logic [3:0] DATA_BITS_BASE = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } rx_state_t;

  // Bit time rounded to the nearest clock: (clk + rate/2) / rate.
  function automatic logic [BT_W-1:0] baud_bt(input logic [3:0] baud, input int clk_hz);
    case (baud)
      4'h0:    baud_bt = BT_W'((clk_hz + 150) / 300);
      4'h1:    baud_bt = BT_W'((clk_hz + 600) / 1200);
      4'h2:    baud_bt = BT_W'((clk_hz + 1200) / 2400);
      4'h3:    baud_bt = BT_W'((clk_hz + 2400) / 4800);
      4'h4:    baud_bt = BT_W'((clk_hz + 4800) / 9600);
      4'h5:    baud_bt = BT_W'((clk_hz + 9600) / 19200);
      4'h6:    baud_bt = BT_W'((clk_hz + 19200) / 38400);
      4'h7:    baud_bt = BT_W'((clk_hz + 28800) / 57600);
      4'h8:    baud_bt = BT_W'((clk_hz + 57600) / 115200);
      4'h9:    baud_bt = BT_W'((clk_hz + 115200) / 230400);
      4'hA:    baud_bt = BT_W'((clk_hz + 230400) / 460800);
      default: baud_bt = BT_W'((clk_hz + 460800) / 921600);
    endcase
  endfunction

  function automatic logic [SHIFT_W-1:0] frame_mask(input logic [3:0] n);
    for (int i = 0; i < SHIFT_W; i++) begin
      if (i < int'(n)) begin
        frame_mask[i] = 1'b1;
      end else begin
        frame_mask[i] = 1'b0;
      end
    end
  endfunction

  function automatic logic expected_parity(input logic [7:0] data, input logic odd);
    expected_parity = (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
// uart_bit_timer: loadable down-counter producing a terminal-count pulse
// exactly L clocks after a load, where L is a full or half bit time.
//   i_clk  : system clock
//   i_rst  : async active-high reset
//   i_load : (re)start the count this cycle
//   i_half : 1 = load half of i_bt (truncated), 0 = load i_bt
//   i_bt   : bit time in clocks
//   o_tc   : high for one cycle when the loaded interval has elapsed
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_half,
  input  logic [BT_W-1:0] i_bt,
  output logic            o_tc
);

  logic [BT_W-1:0] r_cnt;
  logic            r_run;
  logic [BT_W-1:0] w_len;

  assign w_len = i_half ? (i_bt >> 1) : i_bt;
  assign o_tc  = r_run & (r_cnt == '0);

  // Countdown: load L-1 so the terminal count falls on the L-th clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= w_len - BT_W'(1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - BT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
`timescale 1ns/1ps
// uart_rx_engine: oversampling UART receiver, 7/8 data bits LSB first,
// optional odd/even parity, one stop bit.
//   i_clk       : system clock (CLK_HZ)
//   i_rst       : async active-high reset
//   i_rx        : serial line, idles high, asynchronous
//   i_eight     : 1 = 8 data bits, 0 = 7
//   i_pen       : parity enable
//   i_ohel      : parity sense, 1 = odd, 0 = even
//   i_baud      : baud-rate select code
//   o_uart_data : last received character (bit 7 = 0 in 7-bit mode)
//   o_rx_status : one-cycle frame-done pulse
//   o_perr      : parity error of last frame
//   o_ferr      : framing error of last frame
//   o_ovf       : break: every sampled bit of last frame was 0
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_eight,
  input  logic       i_pen,
  input  logic       i_ohel,
  input  logic [3:0] i_baud,
  output logic [7:0] o_uart_data,
  output logic       o_rx_status,
  output logic       o_perr,
  output logic       o_ferr,
  output logic       o_ovf
);

  rx_state_t r_state, w_next;

  logic               r_sync1, r_sync2, r_sync_prev;
  logic [3:0]         r_bitcnt;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_stop;
  logic               r_eight, r_pen, r_ohel;
  logic [BT_W-1:0]    r_bt;

  logic            w_fall, w_tc;
  logic            w_load, w_half, w_clear, w_confirm, w_sample, w_stop_smp;
  logic [BT_W-1:0] w_bt_cur, w_tmr_bt;
  logic [3:0]      w_n;
  logic [7:0]      w_data;
  logic            w_pbit, w_perr, w_ovf;

  assign w_fall   = r_sync_prev & ~r_sync2;
  assign w_bt_cur = baud_bt(i_baud, CLK_HZ);
  assign w_n      = DATA_BITS_BASE + {3'b000, r_eight} + {3'b000, r_pen};

  // Data bits sit at r_shift[0..], the parity bit right after them.
  assign w_data = r_eight ? r_shift[7:0] : {1'b0, r_shift[6:0]};
  assign w_pbit = r_eight ? r_shift[8] : r_shift[7];
  assign w_perr = r_pen & (w_pbit != expected_parity(w_data, r_ohel));
  assign w_ovf  = ((r_shift & frame_mask(w_n)) == '0) & ~r_stop;

  uart_bit_timer u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_half (w_half),
    .i_bt   (w_tmr_bt),
    .o_tc   (w_tc)
  );

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= i_rx;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and timer control. Until the start bit is confirmed the
  // live BAUD input times the frame; afterwards the latched bit time does.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_half     = 1'b0;
    w_clear    = 1'b0;
    w_confirm  = 1'b0;
    w_sample   = 1'b0;
    w_stop_smp = 1'b0;
    w_tmr_bt   = w_bt_cur;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_next  = ST_START;
          w_load  = 1'b1;
          w_half  = 1'b1;
          w_clear = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tc) begin
          if (r_sync2) begin
            w_next = ST_IDLE;
          end else begin
            w_next    = ST_DATA;
            w_load    = 1'b1;
            w_confirm = 1'b1;
          end
        end else begin
          w_next = ST_START;
        end
      end
      ST_DATA: begin
        w_tmr_bt = r_bt;
        if (w_tc) begin
          w_sample = 1'b1;
          w_load   = 1'b1;
          if (r_bitcnt == (w_n - 4'd1)) begin
            w_next = ST_STOP;
          end else begin
            w_next = ST_DATA;
          end
        end else begin
          w_next = ST_DATA;
        end
      end
      ST_STOP: begin
        w_tmr_bt = r_bt;
        if (w_tc) begin
          w_stop_smp = 1'b1;
          w_next     = ST_DONE;
        end else begin
          w_next = ST_STOP;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Frame datapath: bit counter, shift register, stop bit, latched config.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bitcnt <= 4'd0;
      r_shift  <= '0;
      r_stop   <= 1'b1;
      r_eight  <= 1'b0;
      r_pen    <= 1'b0;
      r_ohel   <= 1'b0;
      r_bt     <= '0;
    end else begin
      if (w_clear) begin
        r_bitcnt <= 4'd0;
        r_shift  <= '0;
      end else if (w_sample) begin
        r_shift[r_bitcnt] <= r_sync2;
        r_bitcnt          <= r_bitcnt + 4'd1;
      end
      if (w_confirm) begin
        r_eight <= i_eight;
        r_pen   <= i_pen;
        r_ohel  <= i_ohel;
        r_bt    <= w_bt_cur;
      end
      if (w_stop_smp) begin
        r_stop <= r_sync2;
      end
    end
  end

  // Host-side outputs: refreshed together in DONE, held otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_uart_data <= 8'h00;
      o_rx_status <= 1'b0;
      o_perr      <= 1'b0;
      o_ferr      <= 1'b0;
      o_ovf       <= 1'b0;
    end else begin
      o_rx_status <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        o_uart_data <= w_data;
        o_perr      <= w_perr;
        o_ferr      <= ~r_stop;
        o_ovf       <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
`timescale 1ns/1ps
module tb_uart_rx_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       cfg_eight, cfg_pen, cfg_ohel;
  logic [3:0] cfg_baud;
  logic [7:0] d_data;
  logic       d_status, d_perr, d_ferr, d_ovf;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  int bt_tab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                      868, 434, 217, 109, 109, 109, 109, 109};

  typedef struct {
    logic [3:0] baud;
    logic       eight, pen, ohel;
    logic [7:0] data;
    logic       pbit, stop;
    logic [7:0] e_data;
    logic       e_perr, e_ferr, e_ovf;
  } vec_t;

  vec_t vecs [8];

  uart_rx_engine #(.CLK_HZ(100000000)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .i_eight     (cfg_eight),
    .i_pen       (cfg_pen),
    .i_ohel      (cfg_ohel),
    .i_baud      (cfg_baud),
    .o_uart_data (d_data),
    .o_rx_status (d_status),
    .o_perr      (d_perr),
    .o_ferr      (d_ferr),
    .o_ovf       (d_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (d_status === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: what a correct receiver reports for a given transmitted frame.
  task automatic model(input logic eight, pen, ohel, input logic [7:0] data,
                       input logic pbit, stop, output logic [7:0] e_d,
                       output logic e_p, e_f, e_o);
    int ones;
    logic want;
    e_d  = eight ? data : (data % 8'd128);
    ones = $countones(e_d);
    want = ohel ? (ones % 2 == 0) : (ones % 2 == 1);
    e_p  = pen && (pbit != want);
    e_f  = (stop == 1'b0);
    e_o  = (e_d == 8'h00) && (!pen || pbit == 1'b0) && (stop == 1'b0);
  endtask

  task automatic send_frame(input logic [3:0] baud, input logic eight, pen, ohel,
                            input logic [7:0] data, input logic pbit, stop,
                            input int idle_bits);
    int bt_ns;
    bt_ns     = bt_tab[baud] * 10;
    cfg_baud  = baud;
    cfg_eight = eight;
    cfg_pen   = pen;
    cfg_ohel  = ohel;
    rx = 1'b0;
    #(bt_ns);
    for (int i = 0; i < (eight ? 8 : 7); i++) begin
      rx = data[i];
      #(bt_ns);
    end
    if (pen) begin
      rx = pbit;
      #(bt_ns);
    end
    rx = stop;
    #(bt_ns);
    rx = 1'b1;
    #(idle_bits * bt_ns);
  endtask

  task automatic frame_and_check(input string name, input logic [3:0] baud,
                                 input logic eight, pen, ohel, input logic [7:0] data,
                                 input logic pbit, stop, input int idle_bits,
                                 input logic [7:0] e_d, input logic e_p, e_f, e_o);
    int p0;
    p0 = pulse_cnt;
    send_frame(baud, eight, pen, ohel, data, pbit, stop, idle_bits);
    check({name, ".pulses"}, pulse_cnt - p0, 1);
    check({name, ".data"}, {24'd0, d_data}, {24'd0, e_d});
    check({name, ".perr"}, {31'd0, d_perr}, {31'd0, e_p});
    check({name, ".ferr"}, {31'd0, d_ferr}, {31'd0, e_f});
    check({name, ".ovf"}, {31'd0, d_ovf}, {31'd0, e_o});
  endtask

  initial begin
    logic [7:0] e_d;
    logic       e_p, e_f, e_o;
    int         p0;

    //            baud   8     pen   ohel  data   pbit  stop  e_data e_p   e_f   e_o
    vecs[0] = '{4'h9, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'h9, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'h9, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'h9, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'h9, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{4'hB, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'hB, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{4'hB, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; rx = 1'b1;
    cfg_baud = 4'h9; cfg_eight = 1'b1; cfg_pen = 1'b0; cfg_ohel = 1'b0;
    #100;
    rst = 1'b0;
    #400;
    check("rst.data", {24'd0, d_data}, 32'd0);
    check("rst.status", {31'd0, d_status}, 32'd0);
    check("rst.flags", {29'd0, d_perr, d_ferr, d_ovf}, 32'd0);
    check("rst.pulses", pulse_cnt, 0);

    // Short low glitch, shorter than half a bit at BAUD 9.
    p0 = pulse_cnt;
    rx = 1'b0; #1000; rx = 1'b1; #10000;
    check("glitch.pulses", pulse_cnt - p0, 0);

    for (int i = 0; i < 8; i++) begin
      frame_and_check($sformatf("vec%0d", i), vecs[i].baud, vecs[i].eight, vecs[i].pen,
                      vecs[i].ohel, vecs[i].data, vecs[i].pbit, vecs[i].stop, 1,
                      vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_ovf);
    end

    // Break: line held low for many bit times yields exactly one frame.
    cfg_baud = 4'h9; cfg_eight = 1'b1; cfg_pen = 1'b0; cfg_ohel = 1'b0;
    #4340;
    p0 = pulse_cnt;
    rx = 1'b0;
    #(14 * 4340);
    check("break.pulses", pulse_cnt - p0, 1);
    check("break.data", {24'd0, d_data}, 32'd0);
    check("break.ferr", {31'd0, d_ferr}, 32'd1);
    check("break.ovf", {31'd0, d_ovf}, 32'd1);
    check("break.perr", {31'd0, d_perr}, 32'd0);
    rx = 1'b1;
    #(2 * 4340);

    // Reset in the middle of data bit 3 after a good frame.
    frame_and_check("pre", 4'h9, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1,
                    8'hC3, 1'b0, 1'b0, 1'b0);
    p0 = pulse_cnt;
    rx = 1'b0; #4340;
    rx = 1'b1; #4340;  // 0x77 bit0
    rx = 1'b1; #4340;  // bit1
    rx = 1'b1; #4340;  // bit2
    rx = 1'b0; #2170;  // middle of bit3
    rst = 1'b1; #100; rst = 1'b0;
    rx = 1'b1;
    #(3 * 4340);
    check("midrst.pulses", pulse_cnt - p0, 0);
    check("midrst.data", {24'd0, d_data}, 32'd0);
    check("midrst.flags", {29'd0, d_perr, d_ferr, d_ovf}, 32'd0);
    frame_and_check("post", 4'h9, 1'b1, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1,
                    8'h96, 1'b0, 1'b0, 1'b0);

    // Randomized frames, including back-to-back ones, against the model.
    for (int i = 0; i < 10; i++) begin
      logic [3:0] b;
      logic       e8, pn, oh, pb, sb;
      logic [7:0] dat;
      int         idle;
      b    = ($urandom_range(0, 1) == 0) ? 4'hA : 4'hB;
      e8   = 1'($urandom_range(0, 1));
      pn   = 1'($urandom_range(0, 1));
      oh   = 1'($urandom_range(0, 1));
      pb   = 1'($urandom_range(0, 1));
      sb   = ($urandom_range(0, 3) != 0);
      dat  = 8'($urandom);
      idle = sb ? $urandom_range(0, 2) : 1;
      model(e8, pn, oh, dat, pb, sb, e_d, e_p, e_f, e_o);
      frame_and_check($sformatf("rnd%0d", i), b, e8, pn, oh, dat, pb, sb, idle,
                      e_d, e_p, e_f, e_o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
